// File: rtl/disp_serial_rx.sv
// Serial display-link receiver: oversamples the shift-register protocol,
// deserializes each frame and latches it on the strobe with a framing check.
module disp_serial_rx #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ser_clk,
    input  logic             ser_do,
    input  logic             ser_clr_n,
    input  logic             ser_pen,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_error,
    output logic [7:0]       bit_count
);

    // Bit order {pen, clr_n, do, clk}; clr_n resets high so reset is not a clear.
    localparam logic [3:0] SYNC_RST = 4'b0100;

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [1:0]       prev;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] shreg_nx;
    logic [7:0]       cnt_nx;
    logic             shift_ev;
    logic             latch_ev;
    logic             clr;
    logic             do_s;

    assign shift_ev = s2[0] & ~prev[0];
    assign latch_ev = s2[3] & ~prev[1];
    assign clr      = ~s2[2];
    assign do_s     = s2[1];

    generate
        if (WIDTH == 1) begin : g_w1
            assign shifted = do_s;
        end else begin : g_wn
            assign shifted = {shreg[WIDTH-2:0], do_s};
        end
    endgenerate

    always_comb begin
        shreg_nx = shreg;
        cnt_nx   = bit_count;
        if (clr) begin
            shreg_nx = '0;
            cnt_nx   = 8'd0;
        end else if (shift_ev) begin
            shreg_nx = shifted;
            cnt_nx   = (bit_count == 8'hFF) ? 8'hFF : bit_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1          <= SYNC_RST;
            s2          <= SYNC_RST;
            prev        <= 2'b00;
            shreg       <= '0;
            bit_count   <= 8'd0;
            data        <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            s1         <= {ser_pen, ser_clr_n, ser_do, ser_clk};
            s2         <= s1;
            prev       <= {s2[3], s2[0]};
            shreg      <= shreg_nx;
            data_valid <= latch_ev;
            if (latch_ev) begin
                data        <= shreg_nx;
                frame_error <= (cnt_nx != 8'(WIDTH));
                bit_count   <= 8'd0;
            end else begin
                bit_count <= cnt_nx;
            end
        end
    end

endmodule

// File: tb/tb_disp_serial_rx.sv
// Directed bench for disp_serial_rx: 64-bit and 16-bit instances
// share the serial pins; expected values are hand-computed constants.
module tb_disp_serial_rx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ser_clk = 1'b0;
    logic        ser_do = 1'b0;
    logic        ser_clr_n = 1'b1;
    logic        ser_pen = 1'b0;

    logic [63:0] data;
    logic        data_valid;
    logic        frame_error;
    logic [7:0]  bit_count;
    logic [15:0] data16;
    logic        data_valid16;
    logic        frame_error16;
    logic [7:0]  bit_count16;

    int n_chk  = 0;
    int n_pass = 0;
    int pulses;
    int lat;
    int pulses16;
    int lat16;

    disp_serial_rx #(.WIDTH(64)) dut (
        .clk(clk), .rstn(rstn), .ser_clk(ser_clk), .ser_do(ser_do),
        .ser_clr_n(ser_clr_n), .ser_pen(ser_pen), .data(data),
        .data_valid(data_valid), .frame_error(frame_error),
        .bit_count(bit_count)
    );

    disp_serial_rx #(.WIDTH(16)) dut16 (
        .clk(clk), .rstn(rstn), .ser_clk(ser_clk), .ser_do(ser_do),
        .ser_clr_n(ser_clr_n), .ser_pen(ser_pen), .data(data16),
        .data_valid(data_valid16), .frame_error(frame_error16),
        .bit_count(bit_count16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_do = b;
        tick(2);
        ser_clk = 1'b1;
        tick(3);
        ser_clk = 1'b0;
        tick(3);
    endtask

    task automatic send_word(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pulse_clr();
        ser_clr_n = 1'b0;
        tick(4);
        ser_clr_n = 1'b1;
        tick(3);
    endtask

    // Raises the strobe (optionally with ser_clk) and records valid pulses
    // and the edge count from the pin rise to the first valid sample.
    task automatic do_latch(input logic with_clk);
        pulses = 0; lat = 0; pulses16 = 0; lat16 = 0;
        ser_pen = 1'b1;
        if (with_clk) ser_clk = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (data_valid) begin
                pulses++;
                if (lat == 0) lat = i;
            end
            if (data_valid16) begin
                pulses16++;
                if (lat16 == 0) lat16 = i;
            end
            if (i == 3) begin
                ser_pen = 1'b0;
                ser_clk = 1'b0;
            end
        end
    endtask

    initial begin
        tick(3);
        rstn = 1'b1;
        tick(2);
        chk("rst_data", data, 64'h0);
        chk("rst_valid", {63'h0, data_valid}, 64'h0);
        chk("rst_ferr", {63'h0, frame_error}, 64'h0);
        chk("rst_count", {56'h0, bit_count}, 64'h0);

        pulse_clr();
        send_word(64'h0123456789ABCDEF, 64);
        chk("f1_count_pre", {56'h0, bit_count}, 64'd64);
        do_latch(1'b0);
        chk("f1_data", data, 64'h0123456789ABCDEF);
        chk("f1_pulses", 64'(pulses), 64'd1);
        chk("f1_ferr", {63'h0, frame_error}, 64'h0);
        chk("f1_count_post", {56'h0, bit_count}, 64'h0);

        pulse_clr();
        send_word(64'hA5, 8);
        do_latch(1'b0);
        chk("short_data", data, 64'h00000000000000A5);
        chk("short_ferr", {63'h0, frame_error}, 64'h1);
        send_word(64'h0123456789ABCDEF, 64);
        do_latch(1'b0);
        chk("recover_data", data, 64'h0123456789ABCDEF);
        chk("recover_ferr", {63'h0, frame_error}, 64'h0);

        pulse_clr();
        send_word(64'h3F, 6);
        send_word(64'h0123456789ABCDEF, 64);
        chk("long_count_pre", {56'h0, bit_count}, 64'd70);
        do_latch(1'b0);
        chk("long_data", data, 64'h0123456789ABCDEF);
        chk("long_ferr", {63'h0, frame_error}, 64'h1);

        pulse_clr();
        send_word(64'h7F6E5D4C3B2A1908, 63);
        ser_do = 1'b1;
        tick(2);
        do_latch(1'b1);
        chk("simul_data", data, 64'hFEDCBA9876543211);
        chk("simul_ferr", {63'h0, frame_error}, 64'h0);
        chk("simul_pulses", 64'(pulses), 64'd1);

        send_word(64'h2AAAAAAA, 30);
        pulse_clr();
        send_word(64'hDEADBEEFCAFEF00D, 64);
        do_latch(1'b0);
        chk("clr_mid_data", data, 64'hDEADBEEFCAFEF00D);
        chk("clr_mid_ferr", {63'h0, frame_error}, 64'h0);

        send_word(64'hFFFFF, 20);
        rstn = 1'b0;
        #2;
        chk("arst_data", data, 64'h0);
        chk("arst_count", {56'h0, bit_count}, 64'h0);
        chk("arst_valid", {63'h0, data_valid}, 64'h0);
        chk("arst_data16", {48'h0, data16}, 64'h0);
        tick(2);
        rstn = 1'b1;
        tick(2);
        send_word(64'h0F1E2D3C4B5A6978, 64);
        do_latch(1'b0);
        chk("post_rst_data", data, 64'h0F1E2D3C4B5A6978);
        chk("post_rst_ferr", {63'h0, frame_error}, 64'h0);

        pulse_clr();
        send_word(64'hBEEF, 16);
        chk("w16_count_pre", {56'h0, bit_count16}, 64'd16);
        do_latch(1'b0);
        chk("w16_data", {48'h0, data16}, 64'hBEEF);
        chk("w16_ferr", {63'h0, frame_error16}, 64'h0);
        chk("w16_latency", 64'(lat16), 64'd3);
        chk("w16_pulses", 64'(pulses16), 64'd1);
        chk("w64_short_ferr", {63'h0, frame_error}, 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/disp_serial_rx.md
# disp_serial_rx

Receiver for the board's serial display link (the `seg_*` / `led_*` shift-register protocol driven by the board display driver). It oversamples the serial clock, data, clear and latch lines in the system clock domain and deserializes each frame into a parallel word. It then latches that word on the latch strobe and reports framing errors. It sits on a second board or inside a loopback harness, fed directly by another SoC's display pins, and presents the decoded word to local logic.

## Interface
Parameters:
- `WIDTH`, 64: frame length in bits (64 for the segment chain, 16 for the LED chain); legal range 1..254.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `ser_clk`  in  1  serial shift clock (peer `seg_clk`); idles low, data is taken on its rising edge.
- `ser_do`  in  1  serial data (peer `seg_do`).
- `ser_clr_n`  in  1  chain clear, active-low (peer `seg_clr`).
- `ser_pen`  in  1  latch strobe (peer `seg_pen`); the rising edge transfers the chain to the output.
- `data`  out  WIDTH  last latched frame.
- `data_valid`  out  1  one-cycle pulse when `data` updates.
- `frame_error`  out  1  set at latch if the bit count is not WIDTH; held until the next latch.
- `bit_count`  out  8  bits shifted since the last latch or clear; saturates at 255.

## Operation
- All four serial inputs pass through 2-flop synchronizers. A third register holds the previous synced value for edge detection. `ser_do` uses the identical pipeline, so the data bit seen at a `ser_clk` edge is the pin value at that same instant.
- Shift event, when the synced `ser_clk` rises: `shreg <= {shreg[WIDTH-2:0], do_s}` (MSB first; the first bit shifted ends at `data[WIDTH-1]`), and `bit_count` increments with saturation at 255.
- Clear, while synced `ser_clr_n` is low (level-sensitive): `shreg <= 0` and `bit_count <= 0`. Shift events are ignored during clear. `data`, `frame_error` and `data_valid` are unaffected.
- Latch event, when synced `ser_pen` rises:
  - `data <= shreg`, using the shreg value after any shift event in the same cycle.
  - `frame_error <= (bit_count_next != WIDTH)`.
  - `bit_count <= 0`.
  - `data_valid` pulses.
  - `shreg` is not cleared; a short frame therefore contains the left-shifted residue of the previous frame.
- Simultaneous shift and latch in one cycle: the shift is applied first, and both the new bit and the incremented count are included in the latch.
- Clear and latch in one cycle: clear wins for `shreg`/`bit_count`, and the latch captures the cleared value (all zeros, count 0, so `frame_error` = 1).
- More than WIDTH bits before a latch: only the last WIDTH bits are kept, and `frame_error` = 1.

## Timing
- Reset values: `data` = 0, `data_valid` = 0, `frame_error` = 0, `bit_count` = 0; all synchronizer and edge registers = 0. `ser_clr_n` stages reset to 1 so that reset does not look like a clear.
- Pin-to-effect latency: a pin edge that settles before clk edge N is acted on at clk edge N+2. The shift register and count update at N+2.
- `data_valid` is high for exactly the one cycle after the latch edge N+2, coincident with the new `data`.
- Input requirements on the peer: `ser_clk` high and low phases ≥ 3 clk periods each; `ser_do` stable ≥ 2 clk periods on both sides of the `ser_clk` rising edge; `ser_pen` high ≥ 3 clk periods; `ser_clr_n` low ≥ 3 clk periods. Behaviour on narrower pulses is undefined.
- Reset asserted mid-frame discards all partial state immediately. After release, the first `ser_clk` edge detected is a fresh bit 0; an input already high at release produces no edge.

## Test plan
- Reset, then pulse clear, shift 64 bits of 0x0123456789ABCDEF MSB first, then pulse `ser_pen` → `data` = 0x0123456789ABCDEF, a single one-cycle `data_valid`, `frame_error` = 0, `bit_count` = 0 after the latch.
- Clear, shift 8 bits of 0xA5, latch → `data` = 0x00000000000000A5, `frame_error` = 1; a following correct 64-bit frame clears `frame_error`.
- Clear, shift 70 bits (6 ones followed by 0x0123456789ABCDEF), latch → `data` = 0x0123456789ABCDEF, `frame_error` = 1, `bit_count` = 70 just before the latch.
- Shift 63 bits, then raise `ser_clk` and `ser_pen` on the same clk edge with the 64th bit → the latched frame includes the 64th bit, `frame_error` = 0.
- Shift 30 bits, pulse clear, send a full 64-bit frame, latch → only the new frame appears. Separately: assert `rstn` low mid-frame → all outputs are 0 immediately, and the next full frame decodes correctly.
- `WIDTH` = 16 instance: shift 0xBEEF, latch → `data` = 0xBEEF; measure the latency from the pin `ser_pen` rise to `data_valid` as 3 clk edges.
